pocket_synth: RTL and testbench
===============================

// Module: pocket_synth
//
// PURPOSE
// - Four-key square-wave tone generator: each key plays one fixed note (C4, E4, G4, B4).
// - Keys are synchronised and priority-encoded; the lowest-numbered pressed key wins.
// - Output is a 50%-duty square wave on audio_out, intended to drive a piezo/speaker directly.
// - leds show which note is sounding.
//
// PARAMETERS
// - CLK_FREQ  1_000_000  clock frequency in Hz; all half-periods derive from it.
// - NOTE0_HZ  262        key 0 note (C4).
// - NOTE1_HZ  330        key 1 note (E4).
// - NOTE2_HZ  392        key 2 note (G4).
// - NOTE3_HZ  494        key 3 note (B4).
//
// PORTS
// - clk        in   1  system clock.
// - rst        in   1  reset.
// - keys       in   4  raw key inputs, asynchronous, 1 = pressed.
// - audio_out  out  1  square-wave audio output.
// - leds       out  4  one-hot indicator of the sounding note, or 0 when silent.
// - One clock; reset is synchronous and active-high.
//
// BEHAVIOUR
// - Reset: sync flops, counter, audio_out and leds all 0; note selection = none.
// - Key sync: each keys bit passes through a 2-flop synchroniser. No debounce stage exists.
// - Priority encoder on the synced keys:
//   - lowest set bit selects note index 0..3;
//   - 4'b0000 selects none.
// - Half-period constants, integer-truncated: HALFn = CLK_FREQ / (2*NOTEn_HZ).
//   - At 1 MHz these are 1908, 1515, 1275 and 1012 cycles.
//   - The counter width must hold the largest HALFn - 1.
// - Tone generation:
//   - The counter increments every cycle.
//   - When counter == HALFsel-1, the counter clears to 0 and audio_out toggles.
//   - Resulting period = 2*HALFsel cycles.
// - Note change, i.e. the selected index differs from the previous cycle (includes none -> note):
//   - the counter clears to 0;
//   - audio_out is forced to 1 in that same cycle.
//   - Effect: a rising edge appears 3 cycles after the raw key edge, and the next rising edge follows exactly 2*HALFsel cycles later.
// - No key selected: counter held at 0, audio_out = 0.
// - Key release takes effect after the same 2-cycle sync latency.
// - leds is registered and updates in the same cycle as the note selection: bit n set for note n, otherwise 0.
// - Simultaneous keys: only the lowest index plays; higher keys are ignored until the lower key is released.
//   - Release of the lower key counts as a note change, so the phase restarts.
// - Reset asserted mid-note: silence on the next clock edge; no residual toggling.
//
// STRUCTURE
// - Shared package (synth_pkg):
//   - NOTE_HZ constants;
//   - NUM_KEYS = 4;
//   - function half_period(clk_freq, hz).
// - Sub-module tone_gen:
//   - inputs: clk, rst, enable, restart, half_period;
//   - output: square;
//   - holds the counter and toggle flop.
// - Top level holds the synchroniser, priority encoder, change detector and leds register.
//
// TESTING
// - Clock is 1 MHz, CLK_FREQ = 1_000_000. Release rst, then idle: audio_out = 0 and leds = 0 for 1 ms.
// - keys = 4'b0001 for 4 ms:
//   - first rising edge within 3 cycles;
//   - rising-edge spacing 3816 us (about 262.0 Hz);
//   - leds = 4'b0001.
// - keys 4'b0010, 4'b0100, 4'b1000 in turn, 4 ms each with 1 ms gaps:
//   - spacing 3030, 2550 and 2024 us (about 330, 392 and 494 Hz);
//   - leds match the key.
// - keys = 4'b0101:
//   - C plays (3816 us spacing), leds = 4'b0001;
//   - drop to 4'b0100: G restarts with audio_out = 1 within 3 cycles.
// - Assert rst mid-note: audio_out = 0 and leds = 0 on the next clock edge, and remain 0 while rst is high.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants, types and helpers for the pocket synth.
package synth_pkg;

  localparam int unsigned NUM_KEYS = 4;

  // Default note frequencies in Hz: C4, E4, G4, B4.
  localparam int unsigned NOTE_HZ [NUM_KEYS] = '{262, 330, 392, 494};

  // Selected note: valid = 0 means silence.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } note_sel_t;

  // Half-period in clock cycles, integer-truncated.
  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned hz);
    return clk_freq / (2 * hz);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counter plus toggle flop, with phase restart.
module tone_gen #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] half_period,
  output logic             square
);

  logic [CNT_W-1:0] cnt;

  // Count to half_period-1 then toggle; restart forces the output high at phase 0.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt    <= '0;
      square <= 1'b0;
    end else if (restart) begin
      cnt    <= '0;
      square <= 1'b1;
    end else if (cnt == half_period - 1'b1) begin
      cnt    <= '0;
      square <= ~square;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pocket_synth.sv
// Four-key square-wave tone generator with priority selection and note LEDs.
module pocket_synth
  import synth_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 1_000_000,
  parameter int unsigned NOTE0_HZ = NOTE_HZ[0],
  parameter int unsigned NOTE1_HZ = NOTE_HZ[1],
  parameter int unsigned NOTE2_HZ = NOTE_HZ[2],
  parameter int unsigned NOTE3_HZ = NOTE_HZ[3]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                audio_out,
  output logic [NUM_KEYS-1:0] leds
);

  localparam int unsigned HALF0 = half_period(CLK_FREQ, NOTE0_HZ);
  localparam int unsigned HALF1 = half_period(CLK_FREQ, NOTE1_HZ);
  localparam int unsigned HALF2 = half_period(CLK_FREQ, NOTE2_HZ);
  localparam int unsigned HALF3 = half_period(CLK_FREQ, NOTE3_HZ);
  localparam int unsigned MAX01 = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int unsigned MAX23 = (HALF2 > HALF3) ? HALF2 : HALF3;
  localparam int unsigned MAX_HALF = (MAX01 > MAX23) ? MAX01 : MAX23;
  // Wide enough to hold MAX_HALF-1.
  localparam int unsigned CNT_W = (MAX_HALF > 2) ? $clog2(MAX_HALF) : 1;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  note_sel_t           sel_next;
  note_sel_t           sel_q;
  logic [CNT_W-1:0]    half_sel;
  logic                change;

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Priority encoder: scan high to low so the lowest pressed key wins.
  always_comb begin
    sel_next = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (sync2[i-1]) begin
        sel_next.valid = 1'b1;
        sel_next.idx   = 2'(i - 1);
      end
    end
  end

  assign change = (sel_next != sel_q);

  // Half-period lookup for the newly selected note.
  always_comb begin
    half_sel = CNT_W'(HALF0);
    case (sel_next.idx)
      2'd0:    half_sel = CNT_W'(HALF0);
      2'd1:    half_sel = CNT_W'(HALF1);
      2'd2:    half_sel = CNT_W'(HALF2);
      default: half_sel = CNT_W'(HALF3);
    endcase
  end

  // Remember the previous selection for change detection and drive the LEDs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      leds  <= '0;
    end else begin
      sel_q <= sel_next;
      leds  <= sel_next.valid ? (NUM_KEYS'(1) << sel_next.idx) : '0;
    end
  end

  tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst        (rst),
    .enable     (sel_next.valid),
    .restart    (change),
    .half_period(half_sel),
    .square     (audio_out)
  );

endmodule

// File: tb/tb_pocket_synth.sv
// Self-checking bench for pocket_synth: audio edges scored against a queue.
`timescale 1ns/1ps
module tb_pocket_synth;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = 4'b0000;
  logic       audio_out;
  logic [3:0] leds;

  pocket_synth #(
    .CLK_FREQ(1_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keys     (keys),
    .audio_out(audio_out),
    .leds     (leds)
  );

  // 1 MHz clock.
  always #500 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic        level;
  } edge_t;

  edge_t exp_q[$];
  edge_t exp_e;
  logic  prev_audio = 1'b0;
  int    checks = 0;
  int    failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Every audio transition must match the next expected edge.
  always @(negedge clk) begin
    if (audio_out !== prev_audio) begin
      if (exp_q.size() == 0) begin
        check_val("pending_edge", exp_q.size(), 1);
      end else begin
        exp_e = exp_q.pop_front();
        check_val("edge_cycle", cyc, exp_e.at);
        check_val("edge_level", audio_out, exp_e.level);
      end
    end
    prev_audio = audio_out;
  end

  // Expected edges: rise at start, toggling every half cycles until stop.
  task automatic push_edges(input int unsigned start, input int unsigned half,
                            input int unsigned stop, input bit silent);
    int unsigned t = start;
    logic lvl = 1'b1;
    while (t < stop) begin
      exp_q.push_back('{t, lvl});
      lvl = ~lvl;
      t += half;
    end
    if (silent && !lvl) exp_q.push_back('{stop, 1'b0});
  endtask

  // Hold keys for 'hold' cycles; the note ends end_lat cycles after the hold.
  task automatic play(input logic [3:0] k, input int unsigned hold, input int unsigned half,
                      input bit silent, input int unsigned end_lat, input logic [3:0] exp_leds);
    int unsigned c = cyc;
    keys = k;
    push_edges(c + 3, half, c + hold + end_lat, silent);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        check_val("audio_start", audio_out, 1);
        check_val("leds_on", leds, exp_leds);
      end
      if (i == hold - 1) check_val("leds_hold", leds, exp_leds);
    end
  endtask

  task automatic idle(input int unsigned n);
    keys = 4'b0000;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i % 250 == 249) begin
        check_val("idle_audio", audio_out, 0);
        check_val("idle_leds", leds, 0);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    keys = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    check_val("reset_audio", audio_out, 0);
    check_val("reset_leds", leds, 0);
    rst = 1'b0;
    idle(1000);

    // Single notes, 4 ms each with 1 ms gaps.
    play(4'b0001, 4000, 1908, 1'b1, 3, 4'b0001);
    idle(1000);
    play(4'b0010, 4000, 1515, 1'b1, 3, 4'b0010);
    idle(1000);
    play(4'b0100, 4000, 1275, 1'b1, 3, 4'b0100);
    idle(1000);
    play(4'b1000, 4000, 1012, 1'b1, 3, 4'b1000);
    idle(1000);

    // C wins over G; releasing C restarts G's phase.
    play(4'b0101, 3000, 1908, 1'b0, 3, 4'b0001);
    play(4'b0100, 4000, 1275, 1'b1, 3, 4'b0100);
    idle(1000);

    // Reset mid-note while audio is high.
    play(4'b0001, 1000, 1908, 1'b1, 1, 4'b0001);
    rst = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_audio", audio_out, 0);
      check_val("rst_leds", leds, 0);
    end
    rst  = 1'b0;
    keys = 4'b0000;
    idle(500);

    check_val("edges_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
